// File: rtl/assoc_processor_if.sv
// Host bus of the associative processor: word access port, op start/cmd, read data and done flag.
interface assoc_processor_if #(
   parameter int WORD_SIZE  = 8,
   parameter int CELL_QUANT = 512
);
   localparam int ADDR_W = $clog2(CELL_QUANT);

   logic [ADDR_W-1:0]    addr_in;
   logic [WORD_SIZE-1:0] data_in;
   logic [1:0]           sel_col;
   logic                 sel_internal_col;
   logic                 write_en;
   logic                 read_en;
   logic                 ap_mode;
   logic [2:0]           cmd;
   logic [WORD_SIZE-1:0] data_out;
   logic                 ap_state_irq;

   modport master (
      output addr_in, data_in, sel_col, sel_internal_col, write_en, read_en, ap_mode, cmd,
      input  data_out, ap_state_irq
   );

   modport slave (
      input  addr_in, data_in, sel_col, sel_internal_col, write_en, read_en, ap_mode, cmd,
      output data_out, ap_state_irq
   );
endinterface

// File: rtl/assoc_processor.sv
// Word-parallel, bit-serial associative processor: A/B/C arrays, 2 banks, all rows computed in parallel.
// Optional AP_MULT_EN adds a bit-serial shift-add multiplier for cmd 6 (otherwise cmd 6 runs as OR).
module ap_row #(
   parameter int W  = 8,
   parameter int BW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          bank,
   input  logic [1:0]    sel_col,
   input  logic          wr,
   input  logic [W-1:0]  wdata,
   input  logic          start,
   input  logic          cy_init,
   input  logic          step,
   input  logic [2:0]    op,
   input  logic [BW-1:0] bit_i,
`ifdef AP_MULT_EN
   input  logic          clr_c,
   input  logic [BW-1:0] sh_j,
   input  logic          pass_first,
`endif
   output logic [W-1:0]  rd
);
   logic [1:0][W-1:0] a, b, c;
   logic              cy, cy_n, res;
   logic              a_bit, b_bit;

   function automatic logic maj(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   assign a_bit = a[bank][bit_i];
   assign b_bit = b[bank][bit_i];

`ifdef AP_MULT_EN
   logic          c_bit, pp, cin;
   logic [BW-1:0] a_idx;
   assign a_idx = bit_i - sh_j;
   assign c_bit = c[bank][bit_i];
   assign pp    = a[bank][a_idx] & b[bank][sh_j];
   // carry chain restarts at the first result bit of every partial-product pass
   assign cin   = pass_first ? 1'b0 : cy;
`endif

   always_comb begin
      res  = a_bit | b_bit;
      cy_n = cy;
      case (op)
         3'd1: res = a_bit ^ b_bit;
         3'd2: res = a_bit & b_bit;
         3'd3: res = ~a_bit;
         3'd4: begin
            res  = a_bit ^ b_bit ^ cy;
            cy_n = maj(a_bit, b_bit, cy);
         end
         3'd5: begin
            res  = a_bit ^ ~b_bit ^ cy;
            cy_n = maj(a_bit, ~b_bit, cy);
         end
`ifdef AP_MULT_EN
         3'd6: begin
            res  = c_bit ^ pp ^ cin;
            cy_n = maj(c_bit, pp, cin);
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a[bank] <= '0;
         b[bank] <= '0;
         c[bank] <= '0;
         cy      <= 1'b0;
      end else if (start) begin
         cy <= cy_init;
`ifdef AP_MULT_EN
         if (clr_c) c[bank] <= '0;
`endif
      end else if (step) begin
         c[bank][bit_i] <= res;
         cy             <= cy_n;
      end else if (wr) begin
         case (sel_col)
            2'd0:    a[bank] <= wdata;
            2'd1:    b[bank] <= wdata;
            2'd2:    c[bank] <= wdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      case (sel_col)
         2'd0:    rd = a[bank];
         2'd1:    rd = b[bank];
         2'd2:    rd = c[bank];
         default: rd = '0;
      endcase
   end
endmodule

module assoc_processor #(
   parameter int WORD_SIZE  = 8,
   parameter int CELL_QUANT = 512
) (
   input  logic             CLK100MHZ,
   input  logic             rst,
   assoc_processor_if.slave bus
);
   localparam int ADDR_W = $clog2(CELL_QUANT);
   localparam int BW     = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(WORD_SIZE - 1);

   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

   state_t                               state, state_n;
   logic                                 start, step, last_step;
   logic                                 host_ok, host_wr;
   logic                                 bank_q, bank_act;
   logic [2:0]                           op_q;
   logic [BW-1:0]                        bit_q;
   logic [WORD_SIZE-1:0]                 data_q;
   logic                                 irq_q;
   logic [CELL_QUANT-1:0][WORD_SIZE-1:0] rd_words;

`ifdef AP_MULT_EN
   logic [BW-1:0] sh_q;
   logic          mult_op;
   assign mult_op = (op_q == 3'd6);
`endif

   always_comb begin
`ifdef AP_MULT_EN
      last_step = (bit_q == LAST_BIT) && (!mult_op || sh_q == LAST_BIT);
`else
      last_step = (bit_q == LAST_BIT);
`endif
   end

   always_ff @(posedge CLK100MHZ) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      start   = 1'b0;
      step    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.ap_mode) begin
               state_n = COMPUTE;
               start   = 1'b1;
            end
         end
         COMPUTE: begin
            if (!bus.ap_mode) begin
               state_n = IDLE;
            end else begin
               step = 1'b1;
               if (last_step) state_n = DONE;
            end
         end
         DONE: begin
            if (!bus.ap_mode) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // bit/pass counters; a multiply pass j walks result bits j..WORD_SIZE-1
   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         bit_q  <= '0;
         op_q   <= '0;
         bank_q <= 1'b0;
`ifdef AP_MULT_EN
         sh_q   <= '0;
`endif
      end else if (start) begin
         bit_q  <= '0;
         op_q   <= bus.cmd;
         bank_q <= bus.sel_internal_col;
`ifdef AP_MULT_EN
         sh_q   <= '0;
`endif
      end else if (step) begin
         bit_q <= bit_q + 1'b1;
`ifdef AP_MULT_EN
         if (mult_op && bit_q == LAST_BIT) begin
            sh_q  <= sh_q + 1'b1;
            bit_q <= sh_q + 1'b1;
         end
`endif
      end
   end

   assign host_ok  = (state != COMPUTE) && !bus.ap_mode;
   assign host_wr  = host_ok && bus.write_en && (bus.sel_col != 2'd3);
   assign bank_act = (state == COMPUTE && !rst) ? bank_q : bus.sel_internal_col;

   for (genvar r = 0; r < CELL_QUANT; r++) begin : g_row
      ap_row #(.W(WORD_SIZE), .BW(BW)) u_row (
         .clk        (CLK100MHZ),
         .rst        (rst),
         .bank       (bank_act),
         .sel_col    (bus.sel_col),
         .wr         (host_wr && (bus.addr_in == ADDR_W'(r))),
         .wdata      (bus.data_in),
         .start      (start),
         .cy_init    (bus.cmd == 3'd5),
         .step       (step),
         .op         (op_q),
         .bit_i      (bit_q),
`ifdef AP_MULT_EN
         .clr_c      (bus.cmd == 3'd6),
         .sh_j       (sh_q),
         .pass_first (bit_q == sh_q),
`endif
         .rd         (rd_words[r])
      );
   end

   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         data_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         irq_q <= (state == DONE) && bus.ap_mode;
         if (host_ok && bus.read_en && !bus.write_en) data_q <= rd_words[bus.addr_in];
      end
   end

   assign bus.data_out     = data_q;
   assign bus.ap_state_irq = irq_q;
endmodule

// File: tb/tb_assoc_processor.sv
// Randomized scoreboard bench for assoc_processor against an arithmetic reference model.
module tb_assoc_processor;
   localparam int W  = 8;
   localparam int N  = 512;
   localparam int AW = $clog2(N);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   assoc_processor_if #(.WORD_SIZE(W), .CELL_QUANT(N)) bus();
   assoc_processor #(.WORD_SIZE(W), .CELL_QUANT(N)) dut (.CLK100MHZ(clk), .rst(rst), .bus(bus));

   int    ma[2][N], mb[2][N], mc[2][N];
   int    exp_q[$];
   string name_q[$];
   int    n_pass = 0, n_total = 0;
   bit    mult_en;

   task automatic check(string nm, int act, int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
   endtask

   function automatic int ref_op(int cmd, int a, int b);
      int r;
      case (cmd)
         0: r = a | b;
         1: r = a ^ b;
         2: r = a & b;
         3: r = ~a;
         4: r = a + b;
         5: r = a - b;
         6: r = mult_en ? a * b : (a | b);
         default: r = a | b;
      endcase
      return r & ((1 << W) - 1);
   endfunction

   // monitor: every accepted host read yields data_out one edge later
   initial forever begin
      @(posedge clk);
      if (!rst && bus.read_en && !bus.write_en && !bus.ap_mode) begin
         @(negedge clk);
         if (exp_q.size() == 0) check("read without expectation", exp_q.size(), 1);
         else check(name_q.pop_front(), int'(bus.data_out), exp_q.pop_front());
      end
   end

   task automatic wr(int col, int bank, int addr, int data);
      bus.sel_col = 2'(col); bus.sel_internal_col = 1'(bank);
      bus.addr_in = AW'(addr); bus.data_in = W'(data); bus.write_en = 1'b1;
      @(posedge clk); #1;
      bus.write_en = 1'b0;
      if (col == 0) ma[bank][addr] = data;
      else if (col == 1) mb[bank][addr] = data;
      else if (col == 2) mc[bank][addr] = data;
   endtask

   task automatic rd(int col, int bank, int addr, string nm);
      bus.sel_col = 2'(col); bus.sel_internal_col = 1'(bank);
      bus.addr_in = AW'(addr); bus.read_en = 1'b1;
      exp_q.push_back(col == 0 ? ma[bank][addr] : col == 1 ? mb[bank][addr] :
                      col == 2 ? mc[bank][addr] : 0);
      name_q.push_back($sformatf("%s col%0d b%0d r%0d", nm, col, bank, addr));
      @(posedge clk); #1;
      bus.read_en = 1'b0;
   endtask

   task automatic run_op(int cmd, int bank, string nm);
      int n, lat;
      lat = (cmd == 6 && mult_en) ? W * (W + 1) / 2 + 1 : W + 1;
      bus.cmd = 3'(cmd); bus.sel_internal_col = 1'(bank); bus.ap_mode = 1'b1;
      @(posedge clk); #1;
      n = 0;
      while (n < 100 && !bus.ap_state_irq) begin
         @(posedge clk); #1;
         n++;
      end
      check({nm, " latency"}, n, lat);
      repeat (3) begin @(posedge clk); #1; end
      check({nm, " irq held"}, int'(bus.ap_state_irq), 1);
      bus.ap_mode = 1'b0;
      @(posedge clk); #1;
      check({nm, " irq cleared"}, int'(bus.ap_state_irq), 0);
      for (int i = 0; i < N; i++) mc[bank][i] = ref_op(cmd, ma[bank][i], mb[bank][i]);
   endtask

   initial begin
      int irq_seen, row;
      string ops[8];
      ops = '{"OR", "XOR", "AND", "NOT", "ADD", "SUB", "MULT", "RSV7"};
`ifdef AP_MULT_EN
      mult_en = 1'b1;
`else
      mult_en = 1'b0;
`endif
      foreach (ma[b, i]) begin ma[b][i] = 0; mb[b][i] = 0; mc[b][i] = 0; end
      bus.addr_in = '0; bus.data_in = '0; bus.sel_col = '0; bus.sel_internal_col = 1'b0;
      bus.write_en = 1'b0; bus.read_en = 1'b0; bus.ap_mode = 1'b0; bus.cmd = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 bus.sel_internal_col = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("reset data_out", int'(bus.data_out), 0);
      check("reset irq", int'(bus.ap_state_irq), 0);

      for (int b = 0; b < 2; b++)
         for (int c = 0; c < 3; c++) begin
            rd(c, b, 0, "reset");
            rd(c, b, N - 1, "reset");
         end

      wr(0, 0, 0, 171);
      wr(1, 0, 0, 167);
      wr(3, 0, 0, 55);
      rd(0, 0, 0, "col3 write dropped");
      rd(3, 0, 0, "col3 read");
      for (int c = 4; c <= 5; c++) begin
         run_op(c, 0, ops[c]);
         rd(2, 0, 0, ops[c]);
      end
      for (int c = 0; c <= 3; c++) begin
         run_op(c, 0, ops[c]);
         rd(2, 0, 0, ops[c]);
      end
      rd(2, 1, 0, "bank1 C untouched");
      run_op(7, 0, ops[7]);
      rd(2, 0, 0, ops[7]);

      wr(0, 0, 0, 13); wr(1, 0, 0, 11);
      run_op(6, 0, "MULT13x11");
      rd(2, 0, 0, "MULT13x11");
      wr(0, 0, 0, 200); wr(1, 0, 0, 3);
      run_op(6, 0, "MULT200x3");
      rd(2, 0, 0, "MULT200x3");

      for (int b = 0; b < 2; b++)
         for (int i = 0; i < N; i++) begin
            wr(0, b, i, $urandom_range(0, 255));
            wr(1, b, i, $urandom_range(0, 255));
         end
      run_op(4, 0, "fill ADD");
      for (int i = 0; i < N; i++) rd(2, 0, i, "fill ADD");
      rd(2, 1, N - 1, "fill bank1 C");

      // abort after three compute cycles
      irq_seen = 0;
      bus.cmd = 3'd4; bus.sel_internal_col = 1'b0; bus.ap_mode = 1'b1;
      @(posedge clk); #1;
      repeat (3) begin @(posedge clk); #1; irq_seen |= int'(bus.ap_state_irq); end
      bus.ap_mode = 1'b0;
      @(posedge clk); #1;
      irq_seen |= int'(bus.ap_state_irq);
      wr(0, 0, 7, 99);
      rd(0, 0, 7, "write after abort");
      repeat (8) begin @(posedge clk); #1; irq_seen |= int'(bus.ap_state_irq); end
      check("abort irq never rose", irq_seen, 0);
      run_op(5, 0, "post-abort SUB");
      rd(2, 0, 7, "post-abort SUB");

      repeat (6) begin
         int c, b;
         c = $urandom_range(0, 7);
         b = $urandom_range(0, 1);
         run_op(c, b, ops[c]);
         repeat (6) begin
            row = $urandom_range(0, N - 1);
            rd(2, b, row, ops[c]);
         end
         rd(0, b, row, "A preserved");
         rd(1, b, row, "B preserved");
      end

      repeat (3) @(posedge clk);
      check("scoreboard drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
